// File: rtl/axi4_pkg.sv
// Shared types and constants for the AXI4 burst bridge and its helpers.
package axi4_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10
    } burst_e;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    // Largest legal AxSIZE for a 32-bit data path (4 bytes per beat).
    localparam logic [2:0] MAX_SIZE = 3'd2;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_RESP,
        WR_DATA,
        WR_REQ,
        WR_RESP
    } state_e;

    // A burst is rejected up front if its beat size is wider than the bus
    // or a WRAP burst does not have 2, 4, 8 or 16 beats.
    function automatic logic burst_illegal(input logic [2:0] size,
                                           input logic [1:0] burst,
                                           input logic [7:0] len);
        logic wrapBad;
        wrapBad = (burst == WRAP) &&
                  !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15));
        return (size > MAX_SIZE) || wrapBad;
    endfunction

endpackage

// File: rtl/axi4_addr_gen.sv
// Combinational AXI4 next-beat address generator (FIXED / INCR / WRAP).
module axi4_addr_gen
    import axi4_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [2:0]        size_i,
    input  logic [7:0]        len_i,
    input  logic [1:0]        burst_i,
    output logic [ADDR_W-1:0] next_o
);

    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] wrapMask;

    // WRAP keeps the upper bits of the container and lets only the low bits roll over.
    always_comb begin
        step     = ADDR_W'(1) << size_i;
        wrapMask = ((ADDR_W'(len_i) + ADDR_W'(1)) << size_i) - ADDR_W'(1);
        next_o   = addr_i;
        case (burst_i)
            INCR:    next_o = addr_i + step;
            WRAP:    next_o = (addr_i & ~wrapMask) | ((addr_i + step) & wrapMask);
            default: next_o = addr_i;
        endcase
    end

endmodule

// File: rtl/axi4_burst2mem.sv
// AXI4 slave to native memory bus bridge: one burst at a time, beats
// serialised onto the native valid/ready bus, round-robin AR/AW grant.
module axi4_burst2mem
    import axi4_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int ID_W    = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic [ID_W-1:0]     axi_awid_i,
    input  logic [ADDR_W-1:0]   axi_awaddr_i,
    input  logic [7:0]          axi_awlen_i,
    input  logic [2:0]          axi_awsize_i,
    input  logic [1:0]          axi_awburst_i,
    input  logic                axi_awvalid_i,
    output logic                axi_awready_o,
    input  logic [DATA_W-1:0]   axi_wdata_i,
    input  logic [DATA_W/8-1:0] axi_wstrb_i,
    input  logic                axi_wlast_i,
    input  logic                axi_wvalid_i,
    output logic                axi_wready_o,
    output logic [ID_W-1:0]     axi_bid_o,
    output logic [1:0]          axi_bresp_o,
    output logic                axi_bvalid_o,
    input  logic                axi_bready_i,
    input  logic [ID_W-1:0]     axi_arid_i,
    input  logic [ADDR_W-1:0]   axi_araddr_i,
    input  logic [7:0]          axi_arlen_i,
    input  logic [2:0]          axi_arsize_i,
    input  logic [1:0]          axi_arburst_i,
    input  logic [2:0]          axi_arprot_i,
    input  logic                axi_arvalid_i,
    output logic                axi_arready_o,
    output logic [ID_W-1:0]     axi_rid_o,
    output logic [DATA_W-1:0]   axi_rdata_o,
    output logic [1:0]          axi_rresp_o,
    output logic                axi_rlast_o,
    output logic                axi_rvalid_o,
    input  logic                axi_rready_i,
    output logic                mem_valid_o,
    output logic                mem_instr_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_wstrb_o,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    input  logic                mem_ready_i
);

    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = (TIMEOUT > 0) ? TMO_W'(TIMEOUT - 1) : '0;

    state_e              state_q, state_d;
    logic                prioWr_q, prioWr_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          len_q, len_d;
    logic [2:0]          size_q, size_d;
    logic [1:0]          burst_q, burst_d;
    logic                instr_q, instr_d;
    logic [7:0]          beat_q, beat_d;
    logic                cfgErr_q, cfgErr_d;
    logic                wrErr_q, wrErr_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [1:0]          rresp_q, rresp_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
    logic [TMO_W-1:0]    tmoCnt_q, tmoCnt_d;

    logic [ADDR_W-1:0]   addrNext;
    logic [ADDR_W-1:0]   wordAddr;
    logic                tmoHit;
    logic                unusedBits;

    axi4_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .addr_i  (addr_q),
        .size_i  (size_q),
        .len_i   (len_q),
        .burst_i (burst_q),
        .next_o  (addrNext)
    );

    assign wordAddr   = {addr_q[ADDR_W-1:2], 2'b00};
    assign tmoHit     = (TIMEOUT != 0) && !mem_ready_i && (tmoCnt_q == TMO_LAST);
    assign unusedBits = ^axi_arprot_i[1:0];

    // R/B payloads come straight from registers so they stay stable while waiting for ready.
    assign axi_rid_o   = id_q;
    assign axi_rdata_o = rdata_q;
    assign axi_rresp_o = rresp_q;
    assign axi_rlast_o = (state_q == RD_RESP) && (beat_q == 8'd0);
    assign axi_bid_o   = id_q;
    assign axi_bresp_o = ((state_q == WR_RESP) && (cfgErr_q || wrErr_q)) ? SLVERR : OKAY;

    // Bridge sequencing: arbitration, beat serialisation, error and timeout handling.
    always_comb begin
        state_d       = state_q;
        prioWr_d      = prioWr_q;
        id_d          = id_q;
        addr_d        = addr_q;
        len_d         = len_q;
        size_d        = size_q;
        burst_d       = burst_q;
        instr_d       = instr_q;
        beat_d        = beat_q;
        cfgErr_d      = cfgErr_q;
        wrErr_d       = wrErr_q;
        rdata_d       = rdata_q;
        rresp_d       = rresp_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        tmoCnt_d      = '0;
        axi_arready_o = 1'b0;
        axi_awready_o = 1'b0;
        axi_wready_o  = 1'b0;
        axi_rvalid_o  = 1'b0;
        axi_bvalid_o  = 1'b0;
        mem_valid_o   = 1'b0;
        mem_instr_o   = 1'b0;
        mem_addr_o    = '0;
        mem_wdata_o   = '0;
        mem_wstrb_o   = '0;

        case (state_q)
            IDLE: begin
                axi_arready_o = rst_n_i && axi_arvalid_i && (!prioWr_q || !axi_awvalid_i);
                axi_awready_o = rst_n_i && axi_awvalid_i && (prioWr_q || !axi_arvalid_i);
                if (axi_arready_o) begin
                    id_d     = axi_arid_i;
                    addr_d   = axi_araddr_i;
                    len_d    = axi_arlen_i;
                    size_d   = axi_arsize_i;
                    burst_d  = axi_arburst_i;
                    instr_d  = axi_arprot_i[2];
                    beat_d   = axi_arlen_i;
                    cfgErr_d = burst_illegal(axi_arsize_i, axi_arburst_i, axi_arlen_i);
                    wrErr_d  = 1'b0;
                    if (cfgErr_d) begin
                        rdata_d = '0;
                        rresp_d = SLVERR;
                        state_d = RD_RESP;
                    end else begin
                        state_d = RD_REQ;
                    end
                end else if (axi_awready_o) begin
                    id_d     = axi_awid_i;
                    addr_d   = axi_awaddr_i;
                    len_d    = axi_awlen_i;
                    size_d   = axi_awsize_i;
                    burst_d  = axi_awburst_i;
                    instr_d  = 1'b0;
                    beat_d   = axi_awlen_i;
                    cfgErr_d = burst_illegal(axi_awsize_i, axi_awburst_i, axi_awlen_i);
                    wrErr_d  = 1'b0;
                    state_d  = WR_DATA;
                end
            end
            RD_REQ: begin
                mem_valid_o = 1'b1;
                mem_instr_o = instr_q;
                mem_addr_o  = wordAddr;
                tmoCnt_d    = tmoCnt_q + TMO_W'(1);
                if (mem_ready_i) begin
                    rdata_d = mem_rdata_i;
                    rresp_d = OKAY;
                    state_d = RD_RESP;
                end else if (tmoHit) begin
                    rdata_d = '0;
                    rresp_d = SLVERR;
                    state_d = RD_RESP;
                end
            end
            RD_RESP: begin
                axi_rvalid_o = 1'b1;
                if (axi_rready_i) begin
                    if (beat_q == 8'd0) begin
                        prioWr_d = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        beat_d  = beat_q - 8'd1;
                        addr_d  = addrNext;
                        state_d = cfgErr_q ? RD_RESP : RD_REQ;
                    end
                end
            end
            WR_DATA: begin
                axi_wready_o = 1'b1;
                if (axi_wvalid_i) begin
                    wdata_d = axi_wdata_i;
                    wstrb_d = axi_wstrb_i;
                    if (axi_wlast_i != (beat_q == 8'd0)) begin
                        wrErr_d = 1'b1;
                    end
                    if (cfgErr_q || (axi_wstrb_i == '0)) begin
                        if (beat_q == 8'd0) begin
                            state_d = WR_RESP;
                        end else begin
                            beat_d = beat_q - 8'd1;
                            addr_d = addrNext;
                        end
                    end else begin
                        state_d = WR_REQ;
                    end
                end
            end
            WR_REQ: begin
                mem_valid_o = 1'b1;
                mem_addr_o  = wordAddr;
                mem_wdata_o = wdata_q;
                mem_wstrb_o = wstrb_q;
                tmoCnt_d    = tmoCnt_q + TMO_W'(1);
                if (mem_ready_i || tmoHit) begin
                    if (!mem_ready_i) begin
                        wrErr_d = 1'b1;
                    end
                    if (beat_q == 8'd0) begin
                        state_d = WR_RESP;
                    end else begin
                        beat_d  = beat_q - 8'd1;
                        addr_d  = addrNext;
                        state_d = WR_DATA;
                    end
                end
            end
            WR_RESP: begin
                axi_bvalid_o = 1'b1;
                if (axi_bready_i) begin
                    prioWr_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            prioWr_q <= 1'b0;
            id_q     <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            size_q   <= '0;
            burst_q  <= '0;
            instr_q  <= 1'b0;
            beat_q   <= '0;
            cfgErr_q <= 1'b0;
            wrErr_q  <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= OKAY;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            tmoCnt_q <= '0;
        end else begin
            state_q  <= state_d;
            prioWr_q <= prioWr_d;
            id_q     <= id_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            size_q   <= size_d;
            burst_q  <= burst_d;
            instr_q  <= instr_d;
            beat_q   <= beat_d;
            cfgErr_q <= cfgErr_d;
            wrErr_q  <= wrErr_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            tmoCnt_q <= tmoCnt_d;
        end
    end

endmodule

// File: tb/tb_axi4_burst2mem.sv
// Directed self-checking bench for the AXI4 burst to native memory bridge.
module tb_axi4_burst2mem;
    import axi4_pkg::*;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int ID_W    = 4;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ID_W-1:0]   awid, arid, bid, rid;
    logic [31:0]       awaddr, araddr, wdata, rdata, memAddr, memWdata, memRdata;
    logic [7:0]        awlen, arlen;
    logic [2:0]        awsize, arsize, arprot;
    logic [1:0]        awburst, arburst, bresp, rresp;
    logic [3:0]        wstrb, memWstrb;
    logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic arvalid, arready, rlast, rvalid, rready;
    logic memValid, memInstr, memReady, memStall;

    int checkCount = 0;
    int passCount  = 0;

    logic [31:0]     addrLog[$];
    logic [31:0]     wdataLog[$];
    logic            instrLog[$];
    logic [31:0]     rDataQ[$];
    logic [1:0]      rRespQ[$];
    logic            rLastQ[$];
    logic [ID_W-1:0] rIdQ[$];

    always #5 clk = ~clk;

    axi4_burst2mem #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .axi_awid_i(awid), .axi_awaddr_i(awaddr), .axi_awlen_i(awlen), .axi_awsize_i(awsize),
        .axi_awburst_i(awburst), .axi_awvalid_i(awvalid), .axi_awready_o(awready),
        .axi_wdata_i(wdata), .axi_wstrb_i(wstrb), .axi_wlast_i(wlast),
        .axi_wvalid_i(wvalid), .axi_wready_o(wready),
        .axi_bid_o(bid), .axi_bresp_o(bresp), .axi_bvalid_o(bvalid), .axi_bready_i(bready),
        .axi_arid_i(arid), .axi_araddr_i(araddr), .axi_arlen_i(arlen), .axi_arsize_i(arsize),
        .axi_arburst_i(arburst), .axi_arprot_i(arprot), .axi_arvalid_i(arvalid), .axi_arready_o(arready),
        .axi_rid_o(rid), .axi_rdata_o(rdata), .axi_rresp_o(rresp), .axi_rlast_o(rlast),
        .axi_rvalid_o(rvalid), .axi_rready_i(rready),
        .mem_valid_o(memValid), .mem_instr_o(memInstr), .mem_addr_o(memAddr),
        .mem_wdata_o(memWdata), .mem_wstrb_o(memWstrb),
        .mem_rdata_i(memRdata), .mem_ready_i(memReady)
    );

    // Native memory model: answers one cycle after a request unless stalled; data = 0xA0 + word index.
    always @(negedge clk) begin
        memReady = memValid && !memStall;
        memRdata = 32'hA0 + 32'(memAddr[3:2]);
    end

    // Record every accepted native beat.
    always @(posedge clk) begin
        if (rst_n && memValid && memReady) begin
            addrLog.push_back(memAddr);
            wdataLog.push_back(memWdata);
            instrLog.push_back(memInstr);
        end
    end

    // Global runaway guard.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish, got running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    endtask

    task automatic clearLogs();
        addrLog.delete(); wdataLog.delete(); instrLog.delete();
        rDataQ.delete(); rRespQ.delete(); rLastQ.delete(); rIdQ.delete();
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic sendAr(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input logic [2:0] prot);
        logic ok = 1'b0;
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arprot = prot;
        arvalid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (arready) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1 arvalid = 1'b0;
        checkOutput("arHandshake", ok, 1'b1);
    endtask

    task automatic sendAw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
        logic ok = 1'b0;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst;
        awvalid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (awready) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1 awvalid = 1'b0;
        checkOutput("awHandshake", ok, 1'b1);
    endtask

    task automatic sendW(input logic [31:0] data, input logic [3:0] strb, input logic last);
        logic ok = 1'b0;
        wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (wready) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1 wvalid = 1'b0;
        checkOutput("wHandshake", ok, 1'b1);
    endtask

    task automatic recvR(input int n);
        rready = 1'b1;
        for (int b = 0; b < n; b++) begin
            logic ok = 1'b0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (rvalid) begin
                    ok = 1'b1;
                    rDataQ.push_back(rdata); rRespQ.push_back(rresp);
                    rLastQ.push_back(rlast); rIdQ.push_back(rid);
                    break;
                end
            end
            checkOutput($sformatf("rBeatSeen%0d", b), ok, 1'b1);
            @(posedge clk); #1;
        end
        rready = 1'b0;
    endtask

    task automatic recvB(output logic [3:0] id, output logic [1:0] resp);
        logic ok = 1'b0;
        id = '0; resp = 2'b11;
        bready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bvalid) begin ok = 1'b1; id = bid; resp = bresp; break; end
        end
        @(posedge clk); #1 bready = 1'b0;
        checkOutput("bSeen", ok, 1'b1);
    endtask

    task automatic applyStimulus();
        logic [3:0] gotId;
        logic [1:0] gotResp;
        int         cnt;
        logic [31:0] wrapAddrs[4];

        // Reset state.
        @(negedge clk);
        checkOutput("resetOutputs", {arready, awready, wready, rvalid, bvalid, memValid, memWstrb}, '0);
        checkOutput("resetMemAddr", memAddr, 32'h0);
        @(posedge clk); #1;

        // INCR read of four words, instruction fetch.
        clearLogs();
        sendAr(4'h5, 32'h1000, 8'd3, 3'd2, INCR, 3'b100);
        @(negedge clk);
        checkOutput("memValidRise", memValid, 1'b1);
        @(posedge clk); #1;
        recvR(4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("incrRdata%0d", i), rDataQ[i], 32'hA0 + i);
            checkOutput($sformatf("incrRlast%0d", i), rLastQ[i], (i == 3));
            checkOutput($sformatf("incrRidResp%0d", i), {rIdQ[i], rRespQ[i]}, {4'h5, OKAY});
            checkOutput($sformatf("incrAddr%0d", i), addrLog[i], 32'h1000 + 4 * i);
        end
        checkOutput("incrBeatCount", addrLog.size(), 4);
        checkOutput("incrInstr", instrLog[0], 1'b1);

        // WRAP write crossing the 16-byte container.
        clearLogs();
        wrapAddrs = '{32'h2008, 32'h200C, 32'h2000, 32'h2004};
        sendAw(4'h3, 32'h2008, 8'd3, 3'd2, WRAP);
        for (int i = 0; i < 4; i++) sendW(32'h1111_1111 * (i + 1), 4'hF, (i == 3));
        recvB(gotId, gotResp);
        checkOutput("wrapBidResp", {gotId, gotResp}, {4'h3, OKAY});
        checkOutput("wrapBeatCount", addrLog.size(), 4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("wrapAddr%0d", i), addrLog[i], wrapAddrs[i]);
            checkOutput($sformatf("wrapWdata%0d", i), wdataLog[i], 32'h1111_1111 * (i + 1));
        end
        checkOutput("wrapInstr", instrLog[0], 1'b0);

        // Contention straight after reset: read first, then write, then the pending read.
        doReset();
        clearLogs();
        arid = 4'h1; araddr = 32'h3000; arlen = 8'd0; arsize = 3'd2; arburst = INCR; arprot = 3'b000;
        awid = 4'h2; awaddr = 32'h4000; awlen = 8'd0; awsize = 3'd2; awburst = INCR;
        arvalid = 1'b1; awvalid = 1'b1;
        @(negedge clk);
        checkOutput("arbFirstGrant", {arready, awready}, 2'b10);
        @(posedge clk); #1;
        araddr = 32'h3004; arid = 4'h6;
        recvR(1);
        @(negedge clk);
        checkOutput("arbSecondGrant", {arready, awready}, 2'b01);
        @(posedge clk); #1 awvalid = 1'b0;
        sendW(32'hCAFE_0001, 4'hF, 1'b1);
        recvB(gotId, gotResp);
        checkOutput("arbBidResp", {gotId, gotResp}, {4'h2, OKAY});
        @(negedge clk);
        checkOutput("arbThirdGrant", {arready, awready}, 2'b10);
        @(posedge clk); #1 arvalid = 1'b0;
        recvR(1);
        checkOutput("arbRead1", {rIdQ[0], rDataQ[0]}, {4'h1, 32'hA0});
        checkOutput("arbRead2", {rIdQ[1], rDataQ[1], rRespQ[1]}, {4'h6, 32'hA1, OKAY});
        checkOutput("arbWriteAddr", addrLog[1], 32'h4000);

        // WLAST asserted early: both beats still written, response is SLVERR.
        clearLogs();
        sendAw(4'h7, 32'h5000, 8'd1, 3'd2, INCR);
        sendW(32'h5555_0000, 4'hF, 1'b1);
        sendW(32'h5555_0001, 4'hF, 1'b1);
        recvB(gotId, gotResp);
        checkOutput("wlastBidResp", {gotId, gotResp}, {4'h7, SLVERR});
        checkOutput("wlastBeatCount", addrLog.size(), 2);
        checkOutput("wlastAddr1", addrLog[1], 32'h5004);

        // Oversized read: no native traffic, zero data with SLVERR.
        clearLogs();
        sendAr(4'h8, 32'h5100, 8'd1, 3'd3, INCR, 3'b000);
        recvR(2);
        checkOutput("sizeErrMemCount", addrLog.size(), 0);
        for (int i = 0; i < 2; i++)
            checkOutput($sformatf("sizeErrBeat%0d", i), {rDataQ[i], rRespQ[i], rLastQ[i]},
                        {32'h0, SLVERR, (i == 1)});

        // Native timeout on a stalled read.
        clearLogs();
        memStall = 1'b1;
        sendAr(4'hA, 32'h6000, 8'd0, 3'd2, INCR, 3'b000);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (memValid) cnt++;
            else if (cnt > 0) break;
        end
        checkOutput("tmoValidCycles", cnt, TIMEOUT);
        @(posedge clk); #1;
        recvR(1);
        checkOutput("tmoRbeat", {rIdQ[0], rDataQ[0], rRespQ[0], rLastQ[0]}, {4'hA, 32'h0, SLVERR, 1'b1});
        memStall = 1'b0;

        // Reset during WR_REQ of an 8-beat write.
        clearLogs();
        memStall = 1'b1;
        sendAw(4'h4, 32'h7000, 8'd7, 3'd2, INCR);
        sendW(32'h7777_0000, 4'hF, 1'b0);
        @(negedge clk);
        checkOutput("midBurstValid", memValid, 1'b1);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("postResetOutputs", {memValid, wready, awready, arready, bvalid, rvalid}, 6'b0);
        memStall = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bvalid) cnt++;
        end
        checkOutput("postResetNoB", cnt, 0);
        @(posedge clk); #1;
        sendAr(4'h9, 32'h7004, 8'd0, 3'd2, INCR, 3'b000);
        recvR(1);
        checkOutput("postResetRead", {rIdQ[0], rDataQ[0], rRespQ[0], rLastQ[0]}, {4'h9, 32'hA1, OKAY, 1'b1});
        checkOutput("postResetMemCount", addrLog.size(), 1);
    endtask

    // Drive idle inputs, reset, run the directed vectors and summarise.
    initial begin
        rst_n = 1'b0; memStall = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arprot = '0; arvalid = 1'b0;
        rready = 1'b0;
        @(posedge clk); #1;
        doReset();
        applyStimulus();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/axi4_burst2mem.md
Name: axi4_burst2mem

Overview:
Parametrised successor of the AXI4-Lite-to-native bridge sitting between a core's AXI4 master port and the SoC native memory bus (valid/ready, wstrb==0 means read).
- Adds full AXI4 bursts (FIXED/INCR/WRAP, len up to 255), ID reflection, and round-robin read/write arbitration.
- Adds an error path: SLVERR for unsupported size, illegal WRAP length, WLAST mismatch and mem_ready timeout.
- One transaction in flight; beats are serialised onto the native bus.

Parameters:
ADDR_W, 32, address width of AXI and native bus
DATA_W, 32, data width (must be 32; the size limit is log2(DATA_W/8)=2)
ID_W, 4, AXI ID width
TIMEOUT, 1024, cycles mem_valid may wait for mem_ready before the beat is aborted (0 disables)

Ports:
clk_i  in  1  clock
rst_n_i  in  1  synchronous active-low reset
axi_aw{id,addr,len,size,burst}_i  in  ID_W/ADDR_W/8/3/2  write address channel payload
axi_awvalid_i / axi_awready_o  in/out  1/1  AW handshake
axi_w{data,strb,last}_i  in  DATA_W/DATA_W/8/1  write data payload
axi_wvalid_i / axi_wready_o  in/out  1/1  W handshake
axi_b{id,resp}_o  out  ID_W/2  write response
axi_bvalid_o / axi_bready_i  out/in  1/1  B handshake
axi_ar{id,addr,len,size,burst,prot}_i  in  ID_W/ADDR_W/8/3/2/3  read address payload
axi_arvalid_i / axi_arready_o  in/out  1/1  AR handshake
axi_r{id,data,resp,last}_o  out  ID_W/DATA_W/2/1  read data payload
axi_rvalid_o / axi_rready_i  out/in  1/1  R handshake
mem_valid_o  out  1  native request
mem_instr_o  out  1  instruction fetch (arprot[2] of the current read burst; 0 for writes)
mem_addr_o  out  ADDR_W  word-aligned address {cur[ADDR_W-1:2],2'b00}
mem_wdata_o / mem_wstrb_o  out  DATA_W/DATA_W/8  write data/strobes (0 for reads)
mem_rdata_i / mem_ready_i  in  DATA_W/1  native response

Behaviour:
- Reset (rst_n_i low at a clk_i edge): all valid/ready outputs 0; resp 0; mem_* 0; state IDLE; arbitration priority = read. Applied mid-burst, the in-flight beat is dropped, mem_valid_o is 0 after that edge, and no B/R is issued.
- States: IDLE, RD_REQ, RD_RESP, WR_DATA, WR_REQ, WR_RESP.
- IDLE:
  - axi_arready_o = arvalid & (prio==RD | !awvalid); axi_awready_o = awvalid & (prio==WR | !arvalid).
  - On handshake, latch id/addr/len/size/burst(/prot); beat counter = len; error flag = (size>2) | (WRAP & len not in {1,3,7,15}).
- Read path:
  - RD_REQ: mem_valid_o=1, wstrb=0, held until mem_ready_i. mem_valid_o rises the cycle after the AR handshake.
  - On mem_ready_i, register rdata, go to RD_RESP with rvalid=1 on the next cycle; rlast = (beat==0).
  - Error burst: skip RD_REQ; every beat returns rdata=0, rresp=SLVERR.
  - RD_RESP: hold the R payload until rready. Then beat==0 -> IDLE with prio=WR; else beat--, advance address, RD_REQ.
- Write path:
  - WR_DATA: wready=1; on wvalid, latch wdata/wstrb and go to WR_REQ.
  - Skip WR_REQ, and count the beat, if the burst is in error or wstrb==0 (a zero-strobe beat would read as a read on the native bus).
  - WLAST mismatch: wlast set with beat!=0, or clear with beat==0, sets a sticky error. The beat count still follows len.
  - WR_REQ: mem_valid_o with strobes as given (AXI lanes are already positioned). On ready: beat==0 -> WR_RESP, else beat--, advance address, WR_DATA.
  - WR_RESP: bvalid with bid and bresp = sticky error ? SLVERR : OKAY. On bready -> IDLE with prio=RD.
- Address advance (sub-module):
  - FIXED: no change.
  - INCR: +(1<<size). No 4KB check; the address wraps modulo 2^ADDR_W.
  - WRAP: container = (len+1)<<size; next = (addr & ~(container-1)) | ((addr + (1<<size)) & (container-1)).
- Timeout:
  - The counter clears when mem_valid_o rises and counts while it is high and mem_ready_i is low.
  - At TIMEOUT, mem_valid_o drops and the beat completes as an error: read beat rdata=0/SLVERR; write beat sets the sticky error.
  - mem_ready_i arriving in the same cycle as the timeout wins (normal completion).
- Simultaneous AR/AW: only one is granted per the prio bit, so there is strict alternation under contention.
- The R/B payload is stable while valid & !ready.

Decomposition:
- Package axi4_pkg:
  - burst_e (FIXED=2'b00, INCR=2'b01, WRAP=2'b10)
  - resp constants OKAY=2'b00, SLVERR=2'b10
  - bridge state enum
  - MAX_SIZE=2
- Sub-module axi4_addr_gen: combinational next address from addr/size/len/burst. Reusable by future DMA blocks.

Test Plan:
- INCR read, araddr=0x1000, len=3, size=2, memory returns 0xA0..0xA3 -> mem_addr 0x1000,0x1004,0x1008,0x100C; four R beats with rid echoed, rlast only on the 4th, rresp=OKAY.
- WRAP write, awaddr=0x2008, len=3, size=2 -> mem_addr sequence 0x2008,0x200C,0x2000,0x2004; bresp OKAY.
- AR and AW asserted in the same cycle right after reset -> read granted first, write granted after the read completes; a second contention grants the write first.
- Write len=1 with wlast on beat 0 -> both beats written, bresp=SLVERR. arsize=3 read, len=1 -> no mem_valid, 2 beats of rdata=0, SLVERR.
- Read with mem_ready held low, TIMEOUT=16 -> mem_valid drops after 16 cycles; R beat rresp=SLVERR, data 0; the bridge returns to IDLE.
- rst_n_i low for 1 cycle during WR_REQ of a len=7 burst -> mem_valid 0 and all readies 0 the next cycle, no B issued; a following single read completes OKAY.
